// File: rtl/mbus_int_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ local interrupt sources onto the
// single REQ_INT / CLR_EXT_INT handshake of the MBus interrupt controller.
module mbus_int_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic               CLKIN,
   input  logic               RESETn,
   input  logic [NUM_REQ-1:0] REQ_IN,
   input  logic [NUM_REQ-1:0] MASK,
   input  logic               CLR_EXT_INT,
   output logic               REQ_INT,
   output logic               GRANT_VALID,
   output logic [IDX_W-1:0]   GRANT_IDX,
   output logic [NUM_REQ-1:0] SRC_ACK,
   output logic [NUM_REQ-1:0] PENDING,
   output logic               TIMEOUT_ERR
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t             state;
   logic [NUM_REQ-1:0] req_q;
   logic [IDX_W-1:0]   ptr;
   logic [TO_W-1:0]    count;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] ack_vec;
   logic [NUM_REQ-1:0] clr_vec;
   logic [IDX_W-1:0]   probe;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_found;

   assign eligible = PENDING & ~MASK;
   assign ack_vec  = NUM_REQ'(1) << GRANT_IDX;
   assign clr_vec  = (state == ST_WAIT && CLR_EXT_INT) ? ack_vec : '0;

   // Walk offsets from farthest to nearest so the source closest after ptr wins.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      probe     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         probe = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (eligible[probe]) begin
            sel_found = 1'b1;
            sel_idx   = probe;
         end
      end
   end

   // A fresh rising edge beats a same-cycle acknowledge, so no event is lost.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLKIN or negedge RESETn) begin
      if (!RESETn) begin
         req_q   <= '0;
         PENDING <= '0;
      end else begin
         req_q   <= REQ_IN;
         PENDING <= (PENDING & ~clr_vec) | (REQ_IN & ~req_q);
      end
   end

   always_ff @(posedge CLKIN or negedge RESETn) begin
      if (!RESETn) begin
         state       <= ST_IDLE;
         REQ_INT     <= 1'b0;
         GRANT_VALID <= 1'b0;
         GRANT_IDX   <= '0;
         SRC_ACK     <= '0;
         TIMEOUT_ERR <= 1'b0;
         ptr         <= IDX_W'(NUM_REQ - 1);
         count       <= '0;
      end else begin
         SRC_ACK     <= '0;
         TIMEOUT_ERR <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sel_found) begin
                  GRANT_IDX   <= sel_idx;
                  REQ_INT     <= 1'b1;
                  GRANT_VALID <= 1'b1;
                  count       <= '0;
                  state       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               count <= count + TO_W'(1);
               if (CLR_EXT_INT) begin
                  REQ_INT     <= 1'b0;
                  GRANT_VALID <= 1'b0;
                  SRC_ACK     <= ack_vec;
                  ptr         <= GRANT_IDX;
                  state       <= ST_GAP;
               end else if (count == TO_LAST) begin
                  // Pending bit stays set; moving ptr lets other sources go first.
                  REQ_INT     <= 1'b0;
                  GRANT_VALID <= 1'b0;
                  TIMEOUT_ERR <= 1'b1;
                  ptr         <= GRANT_IDX;
                  state       <= ST_GAP;
               end
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mbus_int_arbiter.md
Name: mbus_int_arbiter

Overview:
- Round-robin arbiter that shares the single layer-controller interrupt request of the MBus interrupt controller among NUM_REQ local interrupt sources.
- Sits between on-chip interrupt sources and the REQ_INT / CLR_EXT_INT pair of the MBus interrupt controller.
- Latches source events as pending, grants one source at a time, and holds REQ_INT until the bus clears it or a timeout expires.
- Acknowledges the serviced source and exposes the granted index so the layer controller knows which source to report.

Parameters:
- NUM_REQ, 4, number of interrupt sources (2..16).
- IDX_W, 2, width of GRANT_IDX; must satisfy 2**IDX_W >= NUM_REQ.
- TIMEOUT, 255, max cycles REQ_INT stays asserted without CLR_EXT_INT (1..2**TO_W-1).
- TO_W, 8, timeout counter width.

Ports:
- CLKIN  input  1  clock.
- RESETn  input  1  asynchronous active-low reset.
- REQ_IN  input  NUM_REQ  source requests; a rising edge on bit i is one interrupt event.
- MASK  input  NUM_REQ  1 = source i is not eligible for grant; its pending bit is kept.
- CLR_EXT_INT  input  1  service-complete from the MBus interrupt controller.
- REQ_INT  output  1  request to the MBus interrupt controller.
- GRANT_VALID  output  1  high while REQ_INT is high.
- GRANT_IDX  output  IDX_W  index of the granted source; valid while GRANT_VALID is high.
- SRC_ACK  output  NUM_REQ  one-cycle one-hot pulse when the granted source is serviced.
- PENDING  output  NUM_REQ  current pending bits.
- TIMEOUT_ERR  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, RESETn low):
  - REQ_INT=0, GRANT_VALID=0, GRANT_IDX=0, SRC_ACK=0, PENDING=0, TIMEOUT_ERR=0.
  - Edge-detect register = 0, round-robin pointer = NUM_REQ-1, counter = 0, state = IDLE.
- Reset mid-grant: drops REQ_INT immediately and loses all pending bits.
- Edge detect:
  - REQ_IN is registered each cycle.
  - Pending bit i is set at the clock edge where REQ_IN[i]=1 and the registered copy is 0.
  - A level held high produces one event only.
- Pending clear: pending bit i is cleared on the SRC_ACK[i] edge. If a new rising edge on i coincides with that clear, set wins and the bit stays 1.
- Eligible set: PENDING & ~MASK.
- Selection: the first eligible index found by searching upward from pointer+1, modulo NUM_REQ. Selection is combinational from the current register state.
- State IDLE:
  - If any source is eligible: register GRANT_IDX = selected index, REQ_INT=1, GRANT_VALID=1, clear counter, go to WAIT.
  - Otherwise stay in IDLE.
  - CLR_EXT_INT is ignored in IDLE.
- State WAIT:
  - REQ_INT and GRANT_IDX are held constant. A MASK change during WAIT does not revoke the grant.
  - Counter increments each cycle.
  - If CLR_EXT_INT=1:
    - REQ_INT=0, GRANT_VALID=0.
    - SRC_ACK[GRANT_IDX]=1 for one cycle, which clears its pending bit.
    - Pointer = GRANT_IDX. Go to GAP.
  - Else if counter == TIMEOUT-1 (REQ_INT high for TIMEOUT cycles):
    - REQ_INT=0, GRANT_VALID=0, TIMEOUT_ERR=1 for one cycle.
    - Pending bit is retained. Pointer = GRANT_IDX, so other sources get priority next. Go to GAP.
  - If CLR_EXT_INT and the timeout fall on the same cycle, CLR_EXT_INT wins: ack, no error.
- State GAP:
  - Guarantees REQ_INT is low for at least 1 cycle between grants.
  - Go to IDLE next cycle. CLR_EXT_INT is ignored.
- Latency:
  - REQ_IN rising before edge k sets pending at edge k.
  - REQ_INT is high after edge k+1.
  - After CLR_EXT_INT is sampled at edge m, the next grant's REQ_INT rises no earlier than edge m+2.
- Fairness: with all sources continuously pending, grants rotate 0,1,...,NUM_REQ-1,0,...
- GRANT_IDX holds its last value when GRANT_VALID=0.
- PENDING is the registered pending vector, with no combinational path from REQ_IN.

Test Plan:
- Reset: RESETn=0 → all outputs 0. Release reset, pulse REQ_IN[2] → PENDING=0100 after 1 edge, REQ_INT=1 with GRANT_IDX=2 one edge later. CLR_EXT_INT 1 cycle → SRC_ACK=0100 pulse, PENDING=0000, REQ_INT=0.
- Round-robin: REQ_IN=1111 simultaneously, CLR_EXT_INT 3 cycles after each REQ_INT rise → GRANT_IDX sequence 0,1,2,3, REQ_INT low ≥1 cycle between grants, 4 SRC_ACK pulses.
- Mask: PENDING=0011, MASK=0001 → grant 1 only. Clear MASK → grant 0 next. PENDING[0] is retained while masked.
- Timeout: TIMEOUT=8, REQ_IN[1] pulse, no CLR_EXT_INT → REQ_INT high exactly 8 cycles, TIMEOUT_ERR pulse, PENDING[1] still 1. Regrant to 1 after the GAP cycle (only source pending).
- Collisions:
  - New REQ_IN[3] rising on the same cycle as its SRC_ACK → PENDING[3]=1 afterwards and it is regranted.
  - CLR_EXT_INT on the cycle of expiry → SRC_ACK, no TIMEOUT_ERR.
- Async reset during WAIT (REQ_INT=1) → REQ_INT=0 without a clock edge, PENDING=0, no SRC_ACK.
